// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the FIFO read controller, the FIFO it drains and
// the downstream consumer. The master modport is the controller's view.
interface fifo_rd_ctrl_if #(
  parameter int data_width  = 6,
  parameter int count_width = 8
);
  logic                   enable;
  logic                   empty_fifo;
  logic                   almost_empty_fifo;
  logic                   error;
  logic [data_width-1:0]  data_out_fifo;
  logic                   rd_enable;
  logic                   ready_in;
  logic                   valid_out;
  logic [data_width-1:0]  data_out;
  logic [count_width-1:0] word_count;
  logic                   err_out;
  logic                   low_level;

  modport master (
    input  enable, empty_fifo, almost_empty_fifo, error, data_out_fifo, ready_in,
    output rd_enable, valid_out, data_out, word_count, err_out, low_level
  );

  modport slave (
    output enable, empty_fifo, almost_empty_fifo, error, data_out_fifo, ready_in,
    input  rd_enable, valid_out, data_out, word_count, err_out, low_level
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains a one-cycle-latency FIFO into a 2-entry skid buffer and presents the
// words downstream on a valid/ready handshake, counting delivered words.
module fifo_rd_ctrl #(
  parameter int data_width  = 6,
  parameter int count_width = 8
) (
  input logic            clk,
  input logic            reset,
  fifo_rd_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, ERROR} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             occ;
  logic                   inflight;
  logic [data_width-1:0]  buf0, buf1;
  logic [count_width-1:0] wcnt;
  logic                   err_q, low_q;
  logic                   pop, rd, cap_slot;

  always_comb begin
    pop = (occ != 2'd0) && bus.ready_in;
    // Reserve a slot for every word already requested, net of this cycle's pop.
    rd  = (state == ACTIVE) && !bus.empty_fifo &&
          (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    cap_slot = (occ == 2'd2) || ((occ == 2'd1) && !pop);

    state_nxt = state;
    if (bus.error) begin
      state_nxt = ERROR;
    end else begin
      case (state)
        IDLE:    if (bus.enable) state_nxt = ACTIVE;
        ACTIVE:  if (!bus.enable) state_nxt = DRAIN;
        DRAIN: begin
          if (bus.enable)                            state_nxt = ACTIVE;
          else if ((occ == 2'd0) && !inflight)       state_nxt = IDLE;
        end
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      wcnt     <= '0;
      err_q    <= 1'b0;
      low_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      low_q <= bus.almost_empty_fifo;
      if (pop) wcnt <= wcnt + count_width'(1);
      if (state_nxt == ERROR) begin
        err_q    <= 1'b1;
        occ      <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= rd;
        occ      <= occ + {1'b0, inflight} - {1'b0, pop};
        if (pop) buf0 <= buf1;
        // Capture lands behind whatever survives this cycle's pop.
        if (inflight) begin
          if (cap_slot) buf1 <= bus.data_out_fifo;
          else          buf0 <= bus.data_out_fifo;
        end
      end
    end
  end

  assign bus.rd_enable  = rd;
  assign bus.valid_out  = (occ != 2'd0);
  assign bus.data_out   = buf0;
  assign bus.word_count = wcnt;
  assign bus.err_out    = err_q;
  assign bus.low_level  = low_q;
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter data_width SHALL be: default 6; width of FIFO words and output data.
REQ-002 Parameter count_width SHALL be: default 8; width of the delivered-word counter.
REQ-003 Port clk SHALL be: input, 1 bit; single clock, all logic on rising edge.
REQ-004 Port reset SHALL be: input, 1 bit; synchronous, active-low reset.
REQ-005 Port enable SHALL be: input, 1 bit; request to drain the FIFO.
REQ-006 Port empty_fifo SHALL be: input, 1 bit; FIFO empty flag.
REQ-007 Port almost_empty_fifo SHALL be: input, 1 bit; FIFO almost-empty flag, status only.
REQ-008 Port error SHALL be: input, 1 bit; FIFO error flag.
REQ-009 Port data_out_fifo SHALL be: input, data_width bits; FIFO read data, valid one cycle after the rd_enable edge.
REQ-010 Port rd_enable SHALL be: output, 1 bit; FIFO read strobe.
REQ-011 Port ready_in SHALL be: input, 1 bit; downstream accepts data.
REQ-012 Port valid_out SHALL be: output, 1 bit; data_out holds a word.
REQ-013 Port data_out SHALL be: output, data_width bits; word presented downstream.
REQ-014 Port word_count SHALL be: output, count_width bits; words delivered since reset.
REQ-015 Port err_out SHALL be: output, 1 bit; sticky error indication.
REQ-016 Port low_level SHALL be: output, 1 bit; registered copy of almost_empty_fifo.

Function
REQ-017 FIFO read latency SHALL be exactly one cycle.
  - rd_enable high at edge N → data_out_fifo captured at edge N+1.
REQ-018 Capture buffer SHALL be a 2-entry in-order skid buffer.
  - occ = 0..2.
  - inflight = 1 for the cycle after a read.
REQ-019 rd_enable SHALL equal (state==ACTIVE) && !empty_fifo && (occ + inflight - pop < 2).
  - pop = valid_out && ready_in in the same cycle.
  - rd_enable SHALL be combinational from registered state and inputs only.
REQ-020 valid_out SHALL be 1 iff occ != 0.
  - data_out SHALL be the oldest buffered word.
REQ-021 Transfer SHALL occur iff valid_out && ready_in at a rising edge.
  - While valid_out && !ready_in, data_out SHALL be held stable.
REQ-022 Capture and transfer in the same cycle SHALL leave occ unchanged.
  - Ordering SHALL be preserved.
REQ-023 With ready_in held high and the FIFO non-empty, throughput SHALL be one word per cycle after the two-cycle fill latency.
  - Fill latency: rd_enable edge → valid_out high one cycle after capture.
REQ-024 word_count SHALL increment by 1 per transfer.
  - Wraps modulo 2^count_width.
REQ-025 States SHALL be IDLE, ACTIVE, DRAIN, ERROR, with transitions:
  - IDLE→ACTIVE when enable=1.
  - ACTIVE→DRAIN when enable=0.
  - DRAIN→IDLE when occ==0 && inflight==0.
  - DRAIN→ACTIVE when enable=1.
  - Any state→ERROR when error=1; ERROR takes priority over all other transitions.
REQ-026 In IDLE and DRAIN, rd_enable SHALL be 0.
  - DRAIN SHALL still deliver buffered and in-flight words.
REQ-027 In ERROR, rd_enable, valid_out SHALL be 0 and err_out SHALL be 1.
  - Buffer contents SHALL be discarded.
  - ERROR exits only on reset.
REQ-028 empty_fifo=1 SHALL suppress rd_enable in the same cycle.
  - A read SHALL never be issued while empty_fifo=1.

Reset
REQ-029 When reset=0 at a rising edge, the block SHALL clear to:
  - state=IDLE, occ=0, inflight=0.
  - rd_enable=0, valid_out=0, data_out=0.
  - word_count=0, err_out=0, low_level=0.
REQ-030 Reset mid-operation SHALL discard buffered and in-flight words.
  - FIFO data arriving the cycle after reset SHALL be ignored.

Verification
REQ-031 Basic drain: FIFO holds 1,2,3,4, enable=1, ready_in=1.
  - rd_enable high 4 cycles.
  - data_out 1,2,3,4 on consecutive cycles.
  - word_count=4, then IDLE after enable=0.
REQ-032 Backpressure: ready_in=0 with FIFO holding 5 words.
  - Exactly 2 reads issued, occ=2, data_out=1 held stable.
  - On ready_in=1, all 5 delivered in order.
REQ-033 Simultaneous: occ=1 with ready_in=1 and a capture in the same cycle.
  - occ stays 1, no word lost or duplicated.
REQ-034 Disable mid-stream: enable→0 with a read in flight.
  - DRAIN delivers the in-flight word.
  - rd_enable stays 0, then IDLE.
REQ-035 Error/reset: error=1 during ACTIVE.
  - Next cycle: err_out=1, valid_out=0, rd_enable=0.
  - reset=0 clears to IDLE, word_count=0.
REQ-036 Counter wrap: count_width=2, 5 transfers → word_count=1.
